// File: rtl/wb_stage.sv
// wb_stage: RISC-V writeback stage; completes ALU results and loads into a registered regfile write port.
// Ports: clk/rst (async active-high reset); in_* upstream instruction with valid/ready handshake;
//        dmem_rvalid/dmem_rdata load response; flush kills in-flight load and incoming instruction;
//        wen/wadd/wdata registered regfile write; busy = occupied or discarding; timeout_err pulse on abandoned load.
module wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_wen,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_result,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        flush,
    output logic        wen,
    output logic [4:0]  wadd,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        timeout_err
);
    typedef enum logic [1:0] {EMPTY, WAIT, FULL} state_t;
    state_t      state, nxt;
    logic        discard, n_discard, n_wen, n_to, acc, rd_wen, n_rd_wen;
    logic [7:0]  cnt, n_cnt, byte_v;
    logic [4:0]  rd, n_rd, n_wadd;
    logic [2:0]  f3, n_f3;
    logic [1:0]  addr, n_addr;
    logic [15:0] half_v;
    logic [31:0] n_wdata, ld_data;
    assign in_ready = ~discard & (state != WAIT);
    assign busy     = (state != EMPTY) | discard;
    always_comb begin
        acc     = in_valid & in_ready & ~flush;
        byte_v  = dmem_rdata[{addr, 3'b000} +: 8];
        half_v  = addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        // reserved funct3 encodings fall through to a full-word load
        ld_data = f3 == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                  f3 == 3'b001 ? {{16{half_v[15]}}, half_v} :
                  f3 == 3'b100 ? {24'h0, byte_v} :
                  f3 == 3'b101 ? {16'h0, half_v} : dmem_rdata;
        nxt       = state;
        n_discard = discard;
        n_cnt     = cnt;
        n_rd      = rd;
        n_rd_wen  = rd_wen;
        n_f3      = f3;
        n_addr    = addr;
        n_wen     = 1'b0;
        n_wadd    = wadd;
        n_wdata   = wdata;
        n_to      = 1'b0;
        if (state == WAIT) begin
            if (flush) begin
                // a response arriving with the flush is consumed here, so nothing is left to discard
                nxt       = EMPTY;
                n_discard = ~dmem_rvalid;
            end else if (dmem_rvalid) begin
                nxt     = FULL;
                n_wen   = rd_wen & (rd != 5'd0);
                n_wadd  = rd;
                n_wdata = ld_data;
            end else if (cnt == 8'(TIMEOUT - 1)) begin
                nxt       = EMPTY;
                n_to      = 1'b1;
                n_discard = 1'b1;
            end else begin
                n_cnt = cnt + 8'd1;
            end
        end else begin
            nxt = EMPTY;
            if (discard & dmem_rvalid)
                n_discard = 1'b0;
            if (acc & in_is_load) begin
                nxt      = WAIT;
                n_rd     = in_rd;
                n_rd_wen = in_rd_wen;
                n_f3     = in_funct3;
                n_addr   = in_result[1:0];
                n_cnt    = 8'd0;
            end else if (acc) begin
                nxt     = FULL;
                n_wen   = in_rd_wen & (in_rd != 5'd0);
                n_wadd  = in_rd;
                n_wdata = in_result;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            discard     <= 1'b0;
            cnt         <= 8'd0;
            rd          <= 5'd0;
            rd_wen      <= 1'b0;
            f3          <= 3'd0;
            addr        <= 2'd0;
            wen         <= 1'b0;
            wadd        <= 5'd0;
            wdata       <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            state       <= nxt;
            discard     <= n_discard;
            cnt         <= n_cnt;
            rd          <= n_rd;
            rd_wen      <= n_rd_wen;
            f3          <= n_f3;
            addr        <= n_addr;
            wen         <= n_wen;
            wadd        <= n_wadd;
            wdata       <= n_wdata;
            timeout_err <= n_to;
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed bench for wb_stage with a cycle-level reference model and literal spot checks.
module tb_wb_stage;
    localparam int TO = 4;
    logic        clk = 1'b0, rst, in_valid, in_ready, in_rd_wen, in_is_load, dmem_rvalid, flush;
    logic        wen, busy, timeout_err;
    logic [4:0]  in_rd, wadd;
    logic [2:0]  in_funct3;
    logic [31:0] in_result, dmem_rdata, wdata;
    int errors = 0, checks = 0, wen_seen = 0, to_seen = 0;
    bit          have_load = 0, drop = 0, full = 0, e_wen = 0, e_to = 0;
    logic [4:0]  ld_rd = 0, e_wadd = 0;
    bit          ld_wen = 0;
    logic [2:0]  ld_f3 = 0;
    logic [1:0]  ld_a = 0;
    logic [31:0] e_wdata = 0;
    int          cyc = 0, acc_cyc = 0;

    wb_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_rd_wen(in_rd_wen), .in_is_load(in_is_load), .in_funct3(in_funct3), .in_result(in_result),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .flush(flush), .wen(wen), .wadd(wadd),
        .wdata(wdata), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext(input logic [2:0] f, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * a)) & 32'hFF;
        h = (d >> (16 * a[1])) & 32'hFFFF;
        case (f)
            3'b000:  return b >= 128 ? b - 32'd256 : b;
            3'b001:  return h >= 32768 ? h - 32'd65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    task automatic model_step();
        cyc++;
        if (rst) begin
            have_load = 0; drop = 0; full = 0; e_wen = 0; e_to = 0; e_wadd = 0; e_wdata = 0;
        end else begin
            e_wen = 0; e_to = 0; full = 0;
            if (have_load) begin
                if (flush) begin
                    have_load = 0; drop = !dmem_rvalid;
                end else if (dmem_rvalid) begin
                    have_load = 0; full = 1;
                    e_wen = ld_wen && ld_rd != 0; e_wadd = ld_rd; e_wdata = ext(ld_f3, ld_a, dmem_rdata);
                end else if (cyc - acc_cyc == TO) begin
                    have_load = 0; e_to = 1; drop = 1;
                end
            end else if (in_valid && !flush && !drop) begin
                if (in_is_load) begin
                    have_load = 1; acc_cyc = cyc;
                    ld_rd = in_rd; ld_wen = in_rd_wen; ld_f3 = in_funct3; ld_a = in_result[1:0];
                end else begin
                    full = 1; e_wen = in_rd_wen && in_rd != 0; e_wadd = in_rd; e_wdata = in_result;
                end
            end else if (drop && dmem_rvalid) begin
                drop = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("wen", {31'b0, wen}, {31'b0, e_wen});
            chk("wadd", {27'b0, wadd}, {27'b0, e_wadd});
            chk("wdata", wdata, e_wdata);
            chk("in_ready", {31'b0, in_ready}, {31'b0, !drop && !have_load});
            chk("busy", {31'b0, busy}, {31'b0, have_load || drop || full});
            chk("timeout_err", {31'b0, timeout_err}, {31'b0, e_to});
            if (wen) wen_seen++;
            if (timeout_err) to_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; dmem_rvalid = 0;
    endtask

    task automatic drive_alu(input logic [4:0] r, input logic [31:0] res, input logic rw);
        in_valid = 1; in_is_load = 0; in_rd = r; in_result = res; in_rd_wen = rw;
    endtask

    task automatic drive_load(input logic [2:0] f, input logic [1:0] a, input logic [4:0] r);
        in_valid = 1; in_is_load = 1; in_funct3 = f; in_result = {30'h0, a}; in_rd = r; in_rd_wen = 1;
    endtask

    task automatic do_load(input string n, input logic [2:0] f, input logic [1:0] a, input logic [4:0] r,
                           input logic [31:0] exp);
        drive_load(f, a, r);
        dmem_rdata = 32'h80FF7F01;
        step();
        in_valid = 0;
        @(negedge clk);
        chk({n, "_ready_wait"}, {31'b0, in_ready}, 32'd0);
        step(); step();
        dmem_rvalid = 1;
        step();
        dmem_rvalid = 0;
        @(negedge clk);
        chk({n, "_wen"}, {31'b0, wen}, {31'b0, r != 0});
        chk({n, "_wdata"}, wdata, exp);
        step();
    endtask

    int w0, t0;

    initial begin
        rst = 1; in_valid = 0; in_rd = 0; in_rd_wen = 0; in_is_load = 0; in_funct3 = 0;
        in_result = 0; dmem_rvalid = 0; dmem_rdata = 0; flush = 0;
        step(); step();
        @(negedge clk);
        chk("rst_wen", {31'b0, wen}, 32'd0);
        chk("rst_wadd", {27'b0, wadd}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_to", {31'b0, timeout_err}, 32'd0);
        rst = 0;
        step();
        drive_alu(5, 32'h1234, 1);
        step();
        idle();
        @(negedge clk);
        chk("alu_wen", {31'b0, wen}, 32'd1);
        chk("alu_wadd", {27'b0, wadd}, 32'd5);
        chk("alu_wdata", wdata, 32'h00001234);
        step();
        @(negedge clk);
        chk("alu_wen_once", {31'b0, wen}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            drive_alu(5'(i), 32'h100 + i, 1);
            step();
            @(negedge clk);
            chk("b2b_ready", {31'b0, in_ready}, 32'd1);
            chk("b2b_wen", {31'b0, wen}, 32'd1);
            chk("b2b_wadd", {27'b0, wadd}, i);
        end
        idle();
        step();
        do_load("lb", 3'b000, 2'd3, 5'd11, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 2'd3, 5'd12, 32'h00000080);
        do_load("lh", 3'b001, 2'd2, 5'd13, 32'hFFFF80FF);
        do_load("lhu", 3'b101, 2'd0, 5'd14, 32'h00007F01);
        do_load("lw", 3'b010, 2'd1, 5'd15, 32'h80FF7F01);
        do_load("rsv", 3'b111, 2'd0, 5'd16, 32'h80FF7F01);
        w0 = wen_seen;
        do_load("ld_rd0", 3'b010, 2'd0, 5'd0, 32'h80FF7F01);
        chk("ld_rd0_nowrite", wen_seen - w0, 32'd0);
        drive_alu(3, 32'h33, 0);
        step();
        idle();
        @(negedge clk);
        chk("alu_nowen", {31'b0, wen}, 32'd0);
        step();
        // response in the acceptance cycle must be ignored
        drive_load(3'b010, 2'd0, 5'd17);
        dmem_rvalid = 1; dmem_rdata = 32'h11111111;
        step();
        idle();
        @(negedge clk);
        chk("acc_rvalid_ignored", {31'b0, busy & ~in_ready}, 32'd1);
        step();
        dmem_rvalid = 1; dmem_rdata = 32'h22222222;
        step();
        idle();
        @(negedge clk);
        chk("late_ld_wdata", wdata, 32'h22222222);
        step();
        // timeout
        w0 = wen_seen; t0 = to_seen;
        drive_load(3'b010, 2'd0, 5'd9);
        step();
        idle();
        repeat (8) step();
        @(negedge clk);
        chk("to_pulses", to_seen - t0, 32'd1);
        chk("to_nowrite", wen_seen - w0, 32'd0);
        chk("to_busy", {31'b0, busy}, 32'd1);
        dmem_rvalid = 1; dmem_rdata = 32'h12345678;
        step();
        idle();
        @(negedge clk);
        chk("to_drop_wen", {31'b0, wen}, 32'd0);
        chk("to_ready_back", {31'b0, in_ready}, 32'd1);
        // flush in WAIT
        drive_load(3'b010, 2'd0, 5'd10);
        step();
        idle();
        flush = 1;
        step();
        flush = 0;
        @(negedge clk);
        chk("fl_discard", {31'b0, busy & ~in_ready}, 32'd1);
        step();
        w0 = wen_seen;
        dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
        step();
        idle();
        @(negedge clk);
        chk("fl_drop", wen_seen - w0, 32'd0);
        chk("fl_ready", {31'b0, in_ready}, 32'd1);
        drive_alu(7, 32'h77, 1);
        step();
        idle();
        @(negedge clk);
        chk("fl_alu_wdata", wdata, 32'h77);
        step();
        // flush coinciding with response: consumed, no discard
        drive_load(3'b010, 2'd0, 5'd18);
        step();
        idle();
        flush = 1; dmem_rvalid = 1;
        step();
        idle();
        @(negedge clk);
        chk("fl_rv_nobusy", {31'b0, busy}, 32'd0);
        // flush in FULL: presented write completes, new input refused
        drive_alu(6, 32'h66, 1);
        step();
        drive_alu(8, 32'h88, 1);
        flush = 1;
        @(negedge clk);
        chk("flfull_wen", {31'b0, wen}, 32'd1);
        step();
        idle();
        @(negedge clk);
        chk("flfull_refused", {31'b0, wen}, 32'd0);
        chk("flfull_wadd", {27'b0, wadd}, 32'd6);
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RISC-V pipeline, directly upstream of the register file. Accepts completed instructions from the memory stage over a valid/ready handshake, waits for data-memory read responses on loads, and byte/half-extracts and sign/zero-extends load data. Produces the registered single-cycle write port (wen/wadd/wdata) that drives the register file. Also provides flush handling and a load-response timeout.

## Interface
- TIMEOUT, 16: maximum number of cycles a load may wait in WAIT for dmem_rvalid; range 2..255.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream has an instruction for writeback.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_rd  in  5  destination register index.
- in_rd_wen  in  1  instruction writes rd.
- in_is_load  in  1  instruction is a load; result comes from dmem_rdata.
- in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- in_result  in  32  ALU result for non-loads; byte address for loads, only bits [1:0] used.
- dmem_rvalid  in  1  data-memory read response valid.
- dmem_rdata  in  32  aligned 32-bit read word.
- flush  in  1  kill the in-flight load and the incoming instruction.
- wen  out  1  register-file write enable.
- wadd  out  5  register-file write address.
- wdata  out  32  register-file write data.
- busy  out  1  state != EMPTY or discard set.
- timeout_err  out  1  one-cycle pulse when a load is abandoned.

## Operation
- States:
  - EMPTY: nothing held.
  - WAIT: load accepted, response pending.
  - FULL: result captured; the write is presented this cycle.
- Accept condition: in_valid & in_ready & ~flush.
  - in_ready = ~discard & (state==EMPTY | state==FULL).
  - in_ready is combinational from state only.
- On accept of a non-load:
  - Go to FULL.
  - Capture wadd=in_rd, wdata=in_result, wen=in_rd_wen & (in_rd!=0).
- On accept of a load:
  - Go to WAIT; latch rd, rd_wen, funct3, addr[1:0]; clear the wait counter.
- In WAIT with dmem_rvalid=1:
  - Go to FULL; wdata = extract(dmem_rdata); wen = rd_wen & (rd!=0).
- Load extraction:
  - LB/LBU: byte addr[1:0].
  - LH/LHU: halfword addr[1]; addr[0] is ignored.
  - LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Reserved funct3 (011, 110, 111) are treated as LW.
- FULL with no new accept goes to EMPTY. FULL with an accept goes to FULL or WAIT per the new instruction, giving back-to-back issue.
- wen is forced to 0 in every state except FULL. wadd and wdata hold their last values when wen=0.
- Timeout:
  - The counter increments each WAIT cycle without dmem_rvalid.
  - When the counter reaches TIMEOUT-1 with no rvalid in that cycle: go to EMPTY, pulse timeout_err, set discard, no write.
- Flush:
  - In WAIT: go to EMPTY and set discard; no write.
  - In FULL: the write already presented completes; next state is EMPTY and the input is not accepted.
  - In EMPTY: the input is not accepted.
- Discard:
  - The next dmem_rvalid clears discard and its data is dropped.
  - dmem_rvalid in EMPTY or FULL with discard=0 is ignored.
- rd=0 instructions still traverse the FSM but never assert wen.

## Timing
- Reset values: state=EMPTY, wen=0, wadd=0, wdata=0, timeout_err=0, discard=0, counter=0, busy=0.
  - Reset mid-load drops the pending load; a later response is ignored, since discard=0 and state=EMPTY.
- Non-load accepted at edge N: wen/wadd/wdata valid during cycle N+1, high for exactly one cycle. Sustained rate is one instruction per cycle.
- Load accepted at edge N: earliest response sampled at edge N+1; dmem_rvalid in the acceptance cycle itself is ignored.
  - rvalid sampled at edge M: wen high during cycle M+1.
- Timeout: if there is no rvalid on edges N+1 .. N+TIMEOUT, the stage is EMPTY after edge N+TIMEOUT and timeout_err is high during the following cycle.
- rvalid and timeout in the same cycle: rvalid wins and the load completes normally.
- flush and rvalid in the same WAIT cycle: flush wins, the data is dropped, and discard stays 0 because that response was consumed.

## Test plan
- Reset with rst=1: all outputs 0. Release rst, then apply in_valid with rd=5, result=0x1234, non-load: wen=1, wadd=5, wdata=0x00001234 for one cycle only.
- Four back-to-back ALU ops to rd=1..4: in_ready stays 1 and wen is high on four consecutive cycles with matching wadd/wdata.
- Loads, all with dmem_rdata=0x80FF7F01 and response 3 cycles later:
  - LB addr=3 → wdata=0xFFFFFF80.
  - LBU addr=3 → 0x00000080.
  - LH addr=2 → 0xFFFF80FF.
  - LHU addr=0 → 0x00007F01.
  - LW → 0x80FF7F01.
  - In each case in_ready=0 during WAIT.
- Load with rd=0: the FSM completes with wen=0 throughout. ALU op with in_rd_wen=0: wen=0.
- TIMEOUT=4, load with no response:
  - timeout_err pulses once, there is no write, and busy stays 1 until a late rvalid arrives.
  - The late rvalid is dropped, then in_ready returns to 1.
- flush in WAIT: no write and discard=1. The next rvalid (data 0xDEADBEEF) is dropped. A following ALU op writes normally.
